// File: rtl/prog_instruction_memory.sv
// Writable instruction memory for the fetch stage: self-clears to NOP after reset,
// accepts a streamed program load, and serves 1-cycle-latency fetches with range check.
module prog_instruction_memory #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_error,
    output logic                  busy
);

    localparam int unsigned PTR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(MEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                state;
    logic [PTR_W-1:0]      clr_ptr;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  wr_en;
    logic [PTR_W-1:0]      wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [PTR_W-1:0]      load_ptr;
    logic                  in_range;

    // The load pointer is the low bits of the word count; no separate register needed.
    assign load_ptr = PTR_W'(load_count);
    assign in_range = ({1'b0, fetch_addr} < DEPTH_CNT);

    // Handshake/status decoded purely from the state register.
    assign fetch_ready = (state == ST_RUN);
    assign load_ready  = (state == ST_LOAD);
    assign busy        = (state != ST_RUN);

    // Single write port shared by the clear sweep and the program loader.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = NOP_WORD;
        case (state)
            ST_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr;
            end
            ST_LOAD: begin
                wr_en   = load_valid;
                wr_addr = load_ptr;
                wr_data = load_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Control FSM with registered fetch outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            load_count  <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= NOP_WORD;
            fetch_error <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        clr_ptr <= '0;
                        state   <= ST_RUN;
                    end else begin
                        clr_ptr <= clr_ptr + PTR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (fetch_req) begin
                        fetch_valid <= 1'b1;
                        if (in_range) begin
                            fetch_instr <= mem[PTR_W'(fetch_addr)];
                            fetch_error <= 1'b0;
                        end else begin
                            fetch_instr <= NOP_WORD;
                            fetch_error <= 1'b1;
                        end
                    end
                    if (load_start) begin
                        load_count <= '0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        load_count <= load_count + CNT_W'(1);
                        // Filling the last word ends the load even without load_last.
                        if (load_last || (load_ptr == LAST_PTR)) begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_instruction_memory.sv
// Scoreboard bench for prog_instruction_memory: stimulus pushes expected fetch results,
// a negedge monitor pops and compares whenever fetch_valid is presented.
module tb_prog_instruction_memory;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 200;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start, load_valid, load_last;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic [AW:0]   load_count;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic          fetch_ready, fetch_valid, fetch_error, busy;
    logic [DW-1:0] fetch_instr;

    prog_instruction_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .NOP_WORD('0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .load_count(load_count),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_error(fetch_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] instr;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] load_q[$];
    logic [DW-1:0] model_mem [256];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            streak = 0;
    int            max_streak = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented fetch must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fetch_valid === 1'b1) begin
            streak++;
            if (streak > max_streak) max_streak = streak;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_fetch_valid: instr 0x%0h with no request outstanding", fetch_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("fetch_instr", 64'(fetch_instr), 64'(e.instr));
                check("fetch_error", 64'(fetch_error), 64'(e.err));
            end
        end else begin
            streak = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller guarantees the DUT is in RUN.
    task automatic do_fetch(input logic [AW-1:0] a);
        exp_t e;
        e.err   = (int'(a) >= int'(DEPTH));
        e.instr = e.err ? '0 : model_mem[a];
        exp_q.push_back(e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    // Releases reset and counts cycles until fetch_ready; a load_start during CLEAR must be dropped.
    task automatic reset_and_clear();
        int cyc = 0;
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0;
        model_clear();
        tick(); tick();
        rst_n = 1'b1;
        while (fetch_ready !== 1'b1 && cyc < 4 * DEPTH) begin
            load_start = (cyc == 5);
            load_valid = (cyc == 6);
            fetch_req  = (cyc == 7);
            tick();
            cyc++;
        end
        load_start = 0; load_valid = 0; fetch_req = 0;
        check("clear_cycles", 64'(cyc), 64'(DEPTH));
        check("run_load_ready", 64'(load_ready), 64'd0);
        check("run_busy", 64'(busy), 64'd0);
    endtask

    // Loads n words (from load_q, else random); ends on load_last or on the final word.
    task automatic do_load(input int n, input bit use_last, input bit toggle, input bit poke);
        int  i = 0;
        int  guard = 0;
        bit  ended = 0;
        exp_t e;
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 255));
        e.err   = (int'(a) >= int'(DEPTH));
        e.instr = e.err ? '0 : model_mem[a];
        exp_q.push_back(e);
        fetch_req = 1'b1; fetch_addr = a; load_start = 1'b1;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        check("load_entry_ready", 64'(load_ready), 64'd1);
        check("load_entry_count", 64'(load_count), 64'd0);
        check("load_entry_busy", 64'(busy), 64'd1);
        while (!ended && guard < 4 * int'(DEPTH)) begin
            logic [DW-1:0] w;
            guard++;
            check("load_fetch_ready", 64'(fetch_ready), 64'd0);
            w = (load_q.size() > 0) ? load_q.pop_front() : $urandom;
            load_valid = !(toggle && guard[0]);
            load_data  = w;
            load_last  = use_last && (i == n - 1);
            load_start = poke && ($urandom_range(0, 3) == 0);
            fetch_req  = poke && $urandom_range(0, 1) == 1;
            fetch_addr = AW'($urandom);
            tick();
            if (load_valid) begin
                model_mem[i] = w;
                i++;
                if (load_last || i == int'(DEPTH)) ended = 1;
            end
        end
        load_valid = 0; load_last = 0; load_start = 0; fetch_req = 0;
        check("load_ended", 64'(ended), 64'd1);
        check("post_load_fetch_ready", 64'(fetch_ready), 64'd1);
        check("load_count", 64'(load_count), 64'(use_last ? n : int'(DEPTH)));
    endtask

    initial begin
        rst_n = 1'b0;
        load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_req = 0; fetch_addr = '0;
        #2;
        check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("rst_fetch_instr", 64'(fetch_instr), 64'd0);
        check("rst_fetch_error", 64'(fetch_error), 64'd0);
        check("rst_load_count", 64'(load_count), 64'd0);
        check("rst_load_ready", 64'(load_ready), 64'd0);
        check("rst_fetch_ready", 64'(fetch_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);

        reset_and_clear();
        for (int a = 0; a < 4; a++) do_fetch(AW'(a));
        drain();

        // Directed program, then fetch past its end.
        load_q = '{32'h00443000, 32'h08843000, 32'h10C01000, 32'h13000001};
        do_load(4, 1, 0, 0);
        for (int a = 0; a < 5; a++) do_fetch(AW'(a));
        drain();
        check("count_held", 64'(load_count), 64'd4);

        max_streak = 0;
        for (int a = 3; a >= 0; a--) do_fetch(AW'(a));
        drain();
        check("b2b_streak", 64'(max_streak), 64'd4);

        do_fetch(AW'(210));
        do_fetch(AW'(199));
        do_fetch(AW'(200));
        drain();

        // Implicit last: toggling valid, no load_last, stray fetch/load_start during LOAD.
        do_load(int'(DEPTH), 0, 1, 1);
        do_fetch(AW'(0));
        do_fetch(AW'(DEPTH - 1));
        do_fetch(AW'(255));
        drain();

        // Randomized partial loads over prior contents.
        for (int r = 0; r < 4; r++) begin
            do_load($urandom_range(1, 40), 1, $urandom_range(0, 1) == 1, 0);
            for (int k = 0; k < 20; k++) do_fetch(AW'($urandom_range(0, 255)));
            drain();
        end

        // Reset in the middle of a load.
        do_load(4, 1, 0, 0);
        drain();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1; load_data = $urandom;
            tick();
        end
        load_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_load_ready", 64'(load_ready), 64'd0);
        check("midrst_load_count", 64'(load_count), 64'd0);
        check("midrst_fetch_instr", 64'(fetch_instr), 64'd0);
        check("midrst_fetch_valid", 64'(fetch_valid), 64'd0);
        check("midrst_fetch_ready", 64'(fetch_ready), 64'd0);
        reset_and_clear();
        for (int a = 0; a < 3; a++) do_fetch(AW'(a));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_instruction_memory.md
# prog_instruction_memory

Writable, parametrised instruction memory for the CPU fetch stage. It replaces the fixed-content ROM with a synchronous RAM that clears itself to NOP after reset and accepts a program through a streaming load port. It serves single-cycle-latency fetches with a valid handshake and flags out-of-range addresses. It sits between the program loader (testbench or boot controller) and the PC/fetch logic.

## Interface
- DATA_WIDTH, 32, instruction width in bits
- ADDR_WIDTH, 8, fetch address width
- MEM_DEPTH, 256, number of words; must satisfy 1 ≤ MEM_DEPTH ≤ 2^ADDR_WIDTH
- NOP_WORD, {DATA_WIDTH{1'b0}}, fill value for clear and out-of-range reads

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  pulse; begins a program load at word 0 (honoured only in RUN)
- load_valid  in  1  load word present
- load_data  in  DATA_WIDTH  load word
- load_last  in  1  qualifies the final load word
- load_ready  out  1  high in LOAD; word accepted when load_valid & load_ready
- load_count  out  ADDR_WIDTH+1  words written by the current/last load
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_WIDTH  word address
- fetch_ready  out  1  high in RUN only
- fetch_valid  out  1  registered; fetch_instr valid this cycle
- fetch_instr  out  DATA_WIDTH  registered instruction
- fetch_error  out  1  registered; set with fetch_valid when address ≥ MEM_DEPTH
- busy  out  1  high in CLEAR or LOAD

## Operation
- FSM states: CLEAR, RUN, LOAD. Reset (async) forces CLEAR, clear pointer 0.
- CLEAR: each cycle writes NOP_WORD at clear pointer, pointer increments. After the write to MEM_DEPTH-1 → RUN. All handshake inputs ignored; load_start here is dropped, not queued.
- RUN: fetch accepted when fetch_req & fetch_ready. Next cycle: fetch_valid=1. If fetch_addr < MEM_DEPTH: fetch_instr=mem[fetch_addr], fetch_error=0. Otherwise: fetch_instr=NOP_WORD, fetch_error=1. With no accepted fetch, fetch_valid=0 and fetch_instr/fetch_error hold their previous values.
- RUN & load_start → LOAD; load pointer and load_count cleared to 0. A fetch accepted in the same cycle still completes normally on the next cycle.
- LOAD: on load_valid & load_ready, write mem[ptr]=load_data, ptr++, load_count++.
  - The word accepted with load_last=1 ends the load → RUN.
  - So does the word written to MEM_DEPTH-1 (implicit last).
  - Words not written keep their prior contents; there is no clear on load.
  - load_start in LOAD is ignored.
- load_count holds its final value in RUN until the next load_start.
- Reset mid-CLEAR or mid-LOAD: immediate return to CLEAR, full re-clear. A partial program is lost.
- Memory write and fetch never coincide: fetch_ready=0 outside RUN, so there is no read-during-write case.

## Timing
- Reset values: fetch_valid=0, fetch_instr=NOP_WORD, fetch_error=0, load_count=0, load_ready=0, fetch_ready=0, busy=1 (CLEAR).
- CLEAR lasts exactly MEM_DEPTH cycles after rst_n deasserts. fetch_ready rises on the first edge after the final clear write.
- Fetch latency: 1 cycle (request at edge N, data valid after edge N+1). Back-to-back fetches sustain 1 per cycle.
- load_ready, fetch_ready and busy are decoded from the state register only, with no combinational path from inputs.
- LOAD→RUN: the cycle after the last word is accepted, fetch_ready=1 and the new word is fetchable.
- Load throughput: 1 word/cycle when load_valid is held high.

## Test plan
- Reset release, idle: count cycles to fetch_ready=1 → exactly MEM_DEPTH. Fetch addr 0..3 → fetch_instr=0, fetch_error=0, fetch_valid one cycle after each req.
- Load 4 words 0x00443000, 0x0884 3000, 0x10C01000, 0x13000001 with load_last on the 4th. Then fetch 0..4 → those words, then 0x00000000. load_count=4.
- Back-to-back fetch of addr 3,2,1,0 on consecutive cycles → fetch_valid high 4 consecutive cycles, data in request order.
- MEM_DEPTH=200, ADDR_WIDTH=8, fetch addr 210 → fetch_instr=NOP_WORD, fetch_error=1. Fetch addr 199 → fetch_error=0.
- Load with load_valid toggling every other cycle and load_last never set → LOAD ends after word MEM_DEPTH-1, load_count=MEM_DEPTH. fetch_ready=0 throughout LOAD; fetch_req during LOAD gives no fetch_valid.
- Assert rst_n=0 after 3 load words: busy=1, outputs return to reset values immediately. After re-clear, fetch addr 0..2 → 0x00000000.
